// File: rtl/ras_ctrl.sv
// Return-address-stack controller: turns fetch slots and branch resolutions into registered stack command strobes.
// Optional event counters are built only when RAS_CTRL_STATS_EN is defined.
module ras_ctrl #(
  parameter int WIDTH        = 32,
  parameter int MAX_BRANCHES = 16,
  parameter int CNT_W        = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             f_valid,
  input  logic             f_call,
  input  logic             f_ret,
  input  logic             f_cond,
  input  logic [WIDTH-1:0] f_ret_addr,
  output logic             f_ready,
  input  logic             r_valid,
  input  logic             r_mispredict,
  output logic             ras_push,
  output logic             ras_pop,
  output logic             ras_branch,
  output logic             ras_close_valid,
  output logic             ras_close_invalid,
  output logic [WIDTH-1:0] ras_din,
  input  logic [WIDTH-1:0] ras_dout,
  input  logic             ras_empty,
  output logic             pred_valid,
  output logic [WIDTH-1:0] pred_addr,
  output logic             pred_empty,
  output logic             err,
  output logic [15:0]      stat_push,
  output logic [15:0]      stat_pop,
  output logic [15:0]      stat_flush
);

  typedef enum logic [0:0] {RUN, FLUSH} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] count, count_next;
  logic             accept, resolve, res_ok, res_err, flush, take, close_ok;

  assign f_ready = (state == RUN) && !(f_cond && (count == CNT_W'(MAX_BRANCHES)));

  // NOTE: every combinational output gets a default before any branch, so no path can infer a latch.
  always_comb begin
    accept     = f_valid && f_ready;
    resolve    = r_valid && (state == RUN);
    res_ok     = resolve && (count != '0);
    res_err    = resolve && (count == '0);
    flush      = res_ok && r_mispredict;
    take       = accept && !flush;
    close_ok   = res_ok && !r_mispredict;
    state_next = state;
    count_next = count;
    if (flush) begin
      state_next = FLUSH;
      count_next = '0;
    end else begin
      if (state == FLUSH) state_next = RUN;
      // A branch accepted alongside a correct resolve cancels out; f_ready keeps the sum within range.
      count_next = count + CNT_W'(take && f_cond) - CNT_W'(close_ok);
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from the same pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= RUN;
      count <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ras_push          <= 1'b0;
      ras_pop           <= 1'b0;
      ras_branch        <= 1'b0;
      ras_close_valid   <= 1'b0;
      ras_close_invalid <= 1'b0;
      ras_din           <= '0;
      pred_valid        <= 1'b0;
      pred_empty        <= 1'b0;
      pred_addr         <= '0;
      err               <= 1'b0;
    end else begin
      ras_push          <= take && f_call;
      ras_pop           <= take && f_ret && !ras_empty;
      ras_branch        <= take && f_cond;
      ras_close_valid   <= close_ok;
      ras_close_invalid <= flush;
      if (take && f_call) ras_din <= f_ret_addr;
      // The stack answers a pop one cycle later; that answer takes precedence over an empty-stack return.
      pred_valid <= ras_pop || (take && f_ret && ras_empty);
      pred_empty <= !ras_pop && take && f_ret && ras_empty;
      if (ras_pop) pred_addr <= ras_dout;
      if (res_err) err <= 1'b1;
    end
  end

`ifdef RAS_CTRL_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_push  <= '0;
      stat_pop   <= '0;
      stat_flush <= '0;
    end else begin
      if (ras_push && (stat_push != 16'hFFFF))           stat_push  <= stat_push + 16'd1;
      if (ras_pop && (stat_pop != 16'hFFFF))             stat_pop   <= stat_pop + 16'd1;
      if (ras_close_invalid && (stat_flush != 16'hFFFF)) stat_flush <= stat_flush + 16'd1;
    end
  end
`else
  assign stat_push  = '0;
  assign stat_pop   = '0;
  assign stat_flush = '0;
`endif

endmodule
